// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op codes, FSM state encoding, flag bundle.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
// Optional multiply feature is selected by the ALU_SEQ_MUL_EN macro in alu_seq.sv.
package alu_seq_pkg;

    // Arithmetic group (L=0)
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEGA = 2'b10;
    localparam logic [1:0] OP_NEGB = 2'b11;

    // Logical group (L=1)
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_MUL  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    typedef struct packed {
        logic z;
        logic c;
        logic s;
    } flags_t;

    // A new start is only taken in IDLE or DONE.
    function automatic logic is_ready(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

    function automatic logic is_busy(input logic [1:0] st);
        return (st == ST_EXEC) || (st == ST_MUL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit ALU: arithmetic/logical result plus z/c/s flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b (W) operands; op (2) select; l (1) logical group;
//        r (W) result; flags (z, c, s).
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    input  logic         l,
    output logic [W-1:0] r,
    output flags_t       flags
);

    localparam logic [W:0] ONE = (W+1)'(1);

    // Arithmetic is done one bit wider so the carry falls out as bit W.
    logic [W:0] sum;

    always_comb begin
        sum   = '0;
        r     = '0;
        flags = '0;
        if (l) begin
            unique case (op)
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                default: r = ~a;
            endcase
            flags.c = 1'b0;
            flags.s = 1'b0;
        end else begin
            unique case (op)
                OP_ADD:  sum = {1'b0, a} + {1'b0, b};
                OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + ONE;
                OP_NEGA: sum = {1'b0, ~a} + ONE;
                default: sum = {1'b0, ~b} + ONE;
            endcase
            r       = sum[W-1:0];
            flags.c = sum[W];
            flags.s = sum[W-1];
        end
        flags.z = (r == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: captures operands on start, runs ALU op (2 edges) or optional shift-add multiply.
// Latency: start at edge n -> results at edge n+1 (ALU) or n+W (multiply); done high the following cycle.
// Backpressure: start is accepted only in IDLE/DONE; starts while busy are dropped. Multiply needs ALU_SEQ_MUL_EN.
// Ports: clk, reset (async, active-high), start, A, B, Op, L, Mul in;
//        R, z, c, s registered results, busy, done (one-cycle pulse) out.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   Op,
    input  logic         L,
    input  logic         Mul,
    output logic [W-1:0] R,
    output logic         z,
    output logic         c,
    output logic         s,
    output logic         busy,
    output logic         done
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;
    logic         l_q, l_d;
    logic [W-1:0] r_q, r_d;
    flags_t       flg_q, flg_d;

    logic [W-1:0] core_r;
    flags_t       core_flags;
    logic         accept;
    logic         mul_req;

`ifdef ALU_SEQ_MUL_EN
    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    // Multiplicand shifts left and multiplier shifts right each step,
    // so every step looks only at bit 0 of the multiplier.
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    assign mul_req = Mul;
`else
    logic unused_mul;
    assign unused_mul = Mul;
    assign mul_req    = 1'b0;
`endif

    assign accept = start && is_ready(state_q);

    alu_core #(.W(W)) u_core (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .l     (l_q),
        .r     (core_r),
        .flags (core_flags)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        l_d     = l_q;
        r_d     = r_q;
        flg_d   = flg_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif

        case (state_q)
            ST_EXEC: begin
                r_d     = core_r;
                flg_d   = core_flags;
                state_d = ST_DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last partial product folds straight into the output registers.
                    r_d     = acc_d[W-1:0];
                    flg_d.z = (acc_d[W-1:0] == '0);
                    flg_d.c = |acc_d[2*W-1:W];
                    flg_d.s = acc_d[W-1];
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Accepting in DONE chains straight into the next operation.
        if (accept) begin
            a_d  = A;
            b_d  = B;
            op_d = Op;
            l_d  = L;
`ifdef ALU_SEQ_MUL_EN
            if (mul_req) begin
                mcand_d  = {{W{1'b0}}, A};
                mplier_d = B;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_MUL;
            end else begin
                state_d  = ST_EXEC;
            end
`else
            state_d = ST_EXEC;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            l_q     <= 1'b0;
            r_q     <= '0;
            flg_q   <= '{z: 1'b1, c: 1'b0, s: 1'b0};
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            l_q     <= l_d;
            r_q     <= r_d;
            flg_q   <= flg_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    assign R    = r_q;
    assign z    = flg_q.z;
    assign c    = flg_q.c;
    assign s    = flg_q.s;
    assign busy = is_busy(state_q);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (W=4): scoreboard of expected results, monitor on done.
// Latency: checks done at 2 edges (ALU) or W+1 edges (multiply) after the issuing cycle.
// Backpressure: exercises starts issued while busy and back-to-back starts in DONE.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] A, B;
    logic [1:0] Op;
    logic       L, Mul;
    logic [3:0] R;
    logic       z, c, s, busy, done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] r;
        logic       z;
        logic       c;
        logic       s;
        int         due;
        string      tag;
    } exp_t;

    exp_t sbq[$];

    alu_seq #(.W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .L     (L),
        .Mul   (Mul),
        .R     (R),
        .z     (z),
        .c     (c),
        .s     (s),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got R=%b z=%b c=%b s=%b at cycle %0d, required no done", R, z, c, s, cyc);
            end else begin
                e = sbq.pop_front();
                if ({R, z, c, s, busy} !== {e.r, e.z, e.c, e.s, 1'b0} || cyc != e.due) begin
                    errors++;
                    $display("FAIL %s: got R=%b z=%b c=%b s=%b busy=%b cycle=%0d, required R=%b z=%b c=%b s=%b busy=0 cycle=%0d",
                             e.tag, R, z, c, s, busy, cyc, e.r, e.z, e.c, e.s, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic chk_outs(input string name, input logic [3:0] er, input logic ez, ec, es, eb, ed);
        chk({name, "_R"},    32'(R),    32'(er));
        chk({name, "_z"},    32'(z),    32'(ez));
        chk({name, "_c"},    32'(c),    32'(ec));
        chk({name, "_s"},    32'(s),    32'(es));
        chk({name, "_busy"}, 32'(busy), 32'(eb));
        chk({name, "_done"}, 32'(done), 32'(ed));
    endtask

    // Drive a start on the next falling edge and queue its expected result.
    task automatic issue(input logic [3:0] a, b, input logic [1:0] op, input logic l, m,
                         input logic [3:0] er, input logic ez, ec, es, input int lat, input string tag);
        exp_t e;
        @(negedge clk);
        A = a; B = b; Op = op; L = l; Mul = m; start = 1'b1;
        e.r = er; e.z = ez; e.c = ec; e.s = es; e.due = cyc + lat; e.tag = tag;
        sbq.push_back(e);
    endtask

    // Drop start and scramble operands so a late input change would corrupt the result.
    task automatic drop();
        @(negedge clk);
        start = 1'b0;
        A = ~A; B = ~B; Op = ~Op; L = ~L; Mul = ~Mul;
    endtask

    task automatic send(input logic [3:0] a, b, input logic [1:0] op, input logic l, m,
                        input logic [3:0] er, input logic ez, ec, es, input int lat, input string tag);
        issue(a, b, op, l, m, er, ez, ec, es, lat, tag);
        drop();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Reference ALU in plain integer arithmetic for W=4.
    function automatic void model(input int a, b, op, l, output logic [3:0] r, output logic ez, ec, es);
        int v;
        if (l != 0) begin
            case (op)
                0:       v = a & b;
                1:       v = a | b;
                2:       v = a ^ b;
                default: v = 15 - a;
            endcase
            ec = 1'b0;
        end else begin
            case (op)
                0:       v = a + b;
                1:       v = a + 16 - b;
                2:       v = 16 - a;
                default: v = 16 - b;
            endcase
            ec = (v >= 16);
        end
        r  = 4'(v % 16);
        es = (l != 0) ? 1'b0 : r[3];
        ez = (r == 4'd0);
    endfunction

    initial begin
        logic [3:0] er;
        logic       ez, ec, es;
        int         n;

        reset = 1'b1; start = 1'b0;
        A = '0; B = '0; Op = '0; L = 1'b0; Mul = 1'b0;
        @(negedge clk);
        chk_outs("reset", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Every ALU operation on every operand pair, issued back-to-back.
        for (int l = 0; l < 2; l++)
            for (int op = 0; op < 4; op++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++) begin
                        model(a, b, op, l, er, ez, ec, es);
                        send(4'(a), 4'(b), 2'(op), 1'(l), 1'b0, er, ez, ec, es, 2,
                             $sformatf("alu_L%0d_op%0d_a%0d_b%0d", l, op, a, b));
                    end
        wait_idle("exh");

        send(4'b0101, 4'b0101, OP_SUB,  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2, "sub_equal");
        send(4'b1111, 4'b0000, OP_NOTA, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2, "nota_ones");
        wait_idle("dir");

        // Outputs hold while idle, even with inputs moving.
        repeat (3) begin
            @(negedge clk);
            A = 4'b1010; B = 4'b0110;
        end
        chk_outs("hold", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
        send(4'b0011, 4'b0101, OP_ADD, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 5, "mul_3x5");
        wait_idle("mul1");
        send(4'b1111, 4'b1111, OP_ADD, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 5, "mul_15x15");
        wait_idle("mul2");

        // Start held every cycle through the multiply: only the first counts.
        issue(4'b0010, 4'b0110, OP_ADD, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b1, 5, "mul_first");
        repeat (4) begin
            @(negedge clk);
            A = 4'b1111; B = 4'b1111; Mul = 1'b1; start = 1'b1;
        end
`else
        send(4'b0111, 4'b0001, OP_ADD, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 2, "mul_ignored");
        wait_idle("nomul");

        // Start during EXEC is dropped.
        issue(4'b0011, 4'b0100, OP_ADD, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 2, "add_first");
        @(negedge clk);
        A = 4'b1111; B = 4'b1111; L = 1'b1; Op = OP_NOTA; start = 1'b1;
`endif
        // Issued in the DONE cycle: back-to-back, no bubble.
        send(4'b0001, 4'b0010, OP_ADD, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 2, "b2b_add");
        wait_idle("b2b");

        // Leave a nonzero result so the reset check below is meaningful.
        send(4'b0111, 4'b0001, OP_ADD, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 2, "pre_reset");
        wait_idle("pre");

        // Abort an operation in flight; it must never produce done.
        @(negedge clk);
        A = 4'b1111; B = 4'b1111; Op = OP_ADD; L = 1'b0; start = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        Mul = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
`else
        Mul = 1'b0;
        @(negedge clk);
        start = 1'b0;
`endif
        reset = 1'b1;
        #1;
        chk_outs("abort", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        send(4'b0010, 4'b0011, OP_ADD, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 2, "add_after_reset");
        wait_idle("post");

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 4, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on rising clk when ready.
REQ-005 A  input  W  operand A, captured on accepted start.
REQ-006 B  input  W  operand B, captured on accepted start.
REQ-007 Op  input  2  operation select, captured on accepted start.
REQ-008 L  input  1  1 = logical group, 0 = arithmetic group, captured on accepted start.
REQ-009 Mul  input  1  1 = unsigned multiply (overrides Op/L), captured on accepted start.
REQ-010 R  output  W  registered result.
REQ-011 z  output  1  registered zero flag.
REQ-012 c  output  1  registered carry/overflow flag.
REQ-013 s  output  1  registered sign flag.
REQ-014 busy  output  1  high while an operation is in progress.
REQ-015 done  output  1  one-cycle pulse when R/z/c/s have just been updated.

Function
REQ-016 FSM states IDLE, EXEC, MUL, DONE; ready = (state is IDLE or DONE).
REQ-017 start in IDLE/DONE: capture A, B, Op, L, Mul; go to MUL if Mul=1 (with macro) else EXEC.
REQ-018 start while busy is ignored; captured operands and outputs unchanged.
REQ-019 EXEC: results written to R/z/c/s on next edge, then DONE; done high 2 edges after start sampled (start at edge n, done high during cycle after edge n+1).
REQ-020 DONE lasts one cycle (done=1, busy=0); to IDLE, or to EXEC/MUL on start (back-to-back, no bubble).
REQ-021 Arithmetic L=0: Op00 A+B; Op01 A+~B+1; Op10 ~A+1; Op11 ~B+1; all computed W+1 bits wide.
REQ-022 Arithmetic flags: c = bit W of the W+1-bit sum; s = R[W-1].
REQ-023 Logical L=1: Op00 A&B; Op01 A|B; Op10 A^B; Op11 ~A; c=0, s=0.
REQ-024 z = 1 iff R == 0, for every operation including multiply.
REQ-025 Multiply: unsigned shift-add, one partial-product step per cycle, exactly W cycles in MUL; R = low W bits of A*B; c = 1 iff high W bits nonzero; s = R[W-1].
REQ-026 Multiply latency: start at edge n, results written at edge n+W, done high during following cycle.
REQ-027 R/z/c/s hold their value between done pulses; never change on rejected start.
REQ-028 A/B/Op/L/Mul changing after acceptance do not affect the operation in flight.

Reset
REQ-029 reset=1 forces state IDLE, R=0, z=1, c=0, s=0, busy=0, done=0, multiply counter 0, immediately and independent of clk.
REQ-030 reset during EXEC or MUL aborts the operation; no done pulse for it; next start after reset release is accepted normally.

Configuration
REQ-031 Macro ALU_SEQ_MUL_EN defined: multiply path, MUL state and counter compiled in.
REQ-032 ALU_SEQ_MUL_EN undefined: Mul port present but ignored (treated as 0); no MUL state or multiply hardware; all other behaviour identical.

Structure
REQ-033 Shared package alu_seq_pkg holds Op code constants (ADD, SUB, NEGA, NEGB, AND, OR, XOR, NOTA) and FSM state encoding.
REQ-034 Combinational W-bit datapath (REQ-021..REQ-024) in sub-module alu_core, instantiated once; alu_seq holds FSM, operand registers, multiplier and output registers.

Verification
REQ-035 W=4, exhaustive A,B 0..15 over all 8 L/Op codes, single ops -> R/z/c/s match REQ-021..024, done 2 edges after start, zero mismatches.
REQ-036 W=4, A=0101 B=0101 L=0 Op=01 -> R=0000 z=1 c=1 s=0; L=1 Op=11 A=1111 -> R=0000 z=1 c=0 s=0.
REQ-037 W=4 macro on, Mul=1 A=0011 B=0101 -> after 4 cycles R=1111 z=0 c=0 s=1 done pulse; A=1111 B=1111 -> R=0001 c=1.
REQ-038 Start pulsed every cycle during multiply -> extra starts ignored, exactly one done, result of first operands only; back-to-back start in DONE -> next done 2 edges later.
REQ-039 reset asserted mid-multiply (cycle 2 of 4) -> outputs R=0 z=1 c=0 s=0 busy=0 immediately, no done; following ADD 0010+0011 -> R=0101.
REQ-040 Macro off, Mul=1 L=0 Op=00 A=0111 B=0001 -> treated as add: R=1000 s=1 c=0, done 2 edges after start.
